// File: rtl/aes_pkg.sv
// Shared AES constants and byte-level helpers for the cipher and decipher cores.
// Holds the S-box table, GF(2^8) column math and round-key slicing.
package aes_pkg;

  localparam int BLK_W  = 128;
  localparam int MAX_NR = 14;
  localparam int MAX_KW = 128 * (MAX_NR + 1);

  typedef enum logic [1:0] {
    PH_LOAD,
    PH_ROUND,
    PH_FINAL,
    PH_DONE
  } aes_phase_e;

  // Byte b lives at bits [2047-8b -: 8], i.e. low bit 8*(255-b).
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    inv_sbox = 8'h00;
    for (int i = 0; i < 256; i++) begin
      if (sbox(8'(i)) == b) inv_sbox = 8'(i);
    end
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul2(input logic [7:0] b);
    gmul2 = xtime(b);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] b);
    gmul3 = xtime(b) ^ b;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    mix_column = {gmul2(a0) ^ gmul3(a1) ^ a2 ^ a3,
                  a0 ^ gmul2(a1) ^ gmul3(a2) ^ a3,
                  a0 ^ a1 ^ gmul2(a2) ^ gmul3(a3),
                  gmul3(a0) ^ a1 ^ a2 ^ gmul2(a3)};
  endfunction

  // Round key r is the r-th 128-bit word counted from the top of the schedule.
  function automatic logic [127:0] rk(input logic [MAX_KW-1:0] w, input logic [3:0] r,
                                      input logic [3:0] nr);
    logic [10:0] lo;
    lo = {nr - r, 7'b0000000};
    rk = (r > nr) ? 128'h0 : w[lo +: 128];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational single-byte AES S-box lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  assign y_o = sbox(a_i);

endmodule

// File: rtl/aes_cipher.sv
// Iterative AES encryption core, one round per clock, driven by a pre-expanded
// key schedule; the state register is exposed directly on out.
module aes_cipher
  import aes_pkg::*;
#(
  parameter int BW = 128,
  parameter int NR = 10,
  parameter int NK = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [BW-1:0]           in,
  input  logic [128*(NR+1)-1:0]   w,
  output logic [BW-1:0]           out,
  input  logic                    en,
  input  logic                    set1,
  input  logic                    set2
);

  if (BW != BLK_W || NR != NK + 6 || !(NK == 4 || NK == 6 || NK == 8)) begin : g_cfg_err
    $error("aes_cipher: unsupported BW/NR/NK combination");
  end

  localparam logic [3:0] LAST_RND = 4'(NR);
  localparam logic [3:0] DONE_RND = 4'(NR + 1);

  logic [BW-1:0]     state_q, state_d;
  logic [3:0]        rnd_q, rnd_d;
  logic [MAX_KW-1:0] wExt;
  logic [127:0]      roundKey;
  logic [BW-1:0]     subBytes, shifted, mixed;
  aes_phase_e        phase;

  assign wExt     = MAX_KW'(w);
  assign roundKey = rk(wExt, rnd_q, LAST_RND);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .a_i(state_q[127-8*i -: 8]),
      .y_o(subBytes[127-8*i -: 8])
    );
  end

  // Row r of the output takes column (c+r) mod 4 of the substituted state.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shifted[127-8*(4*c+r) -: 8] = subBytes[127-8*(4*((c+r)%4)+r) -: 8];
    end
    assign mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
  end

  always_comb begin
    phase = PH_DONE;
    if (rnd_q == 4'd0)          phase = PH_LOAD;
    else if (rnd_q < LAST_RND)  phase = PH_ROUND;
    else if (rnd_q == LAST_RND) phase = PH_FINAL;
  end

  // Restart beats hold; hold freezes both the state and the round counter.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    if (set1 && set2) begin
      state_d = '0;
      rnd_d   = 4'd0;
    end else if (!en) begin
      unique case (phase)
        PH_LOAD: begin
          state_d = in ^ roundKey;
          rnd_d   = 4'd1;
        end
        PH_ROUND: begin
          state_d = mixed ^ roundKey;
          rnd_d   = rnd_q + 4'd1;
        end
        PH_FINAL: begin
          state_d = shifted ^ roundKey;
          rnd_d   = DONE_RND;
        end
        PH_DONE: begin
          state_d = state_q;
          rnd_d   = rnd_q;
        end
        default: begin
          state_d = state_q;
          rnd_d   = rnd_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      rnd_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
    end
  end

  assign out = state_q;

endmodule

// File: tb/tb_aes_cipher.sv
// Self-checking bench for the AES-128/192/256 cipher cores against a byte-array
// reference model that derives its S-box from GF(2^8) inversion.
module tb_aes_cipher;

  logic          clk = 1'b0;
  logic          rst_n, en, set1, set2;
  logic [127:0]  ptIn, out128, out192, out256;
  logic [1407:0] w128;
  logic [1663:0] w192;
  logic [1919:0] w256;

  logic [7:0]    sboxT [256];
  logic [31:0]   ws128 [60];
  logic [31:0]   ws192 [60];
  logic [31:0]   ws256 [60];
  int            checkCount = 0;
  int            failCount  = 0;
  int            advCnt     = 0;
  logic [127:0]  ptLatched  = '0;

  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] E1    = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] E2    = 128'h89d810e8855ace682d1843d8cb128fe4;
  localparam logic [127:0] C128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_cipher #(.BW(128), .NR(10), .NK(4)) u_aes128 (
    .clk(clk), .rst_n(rst_n), .in(ptIn), .w(w128), .out(out128),
    .en(en), .set1(set1), .set2(set2));
  aes_cipher #(.BW(128), .NR(12), .NK(6)) u_aes192 (
    .clk(clk), .rst_n(rst_n), .in(ptIn), .w(w192), .out(out192),
    .en(en), .set1(set1), .set2(set2));
  aes_cipher #(.BW(128), .NR(14), .NK(8)) u_aes256 (
    .clk(clk), .rst_n(rst_n), .in(ptIn), .w(w256), .out(out256),
    .en(en), .set1(set1), .set2(set2));

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
    logic [7:0] v;
    v = b;
    for (int i = 0; i < k; i++) v = {v[6:0], v[7]};
    return v;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] x);
    return {sboxT[x[31:24]], sboxT[x[23:16]], sboxT[x[15:8]], sboxT[x[7:0]]};
  endfunction

  function automatic logic [7:0] rkByte(input logic [31:0] ws [60], input int r, input int i);
    return 8'(ws[4*r + i/4] >> (24 - 8*(i%4)));
  endfunction

  // State after a given number of advancing edges: AddRoundKey, then full rounds,
  // the last round dropping MixColumns.
  function automatic logic [127:0] refState(input logic [127:0] pt, input logic [31:0] ws [60],
                                            input int nr, input int steps);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] tmp;
    if (steps == 0) return '0;
    tmp = pt;
    for (int i = 0; i < 16; i++) begin
      s[i] = tmp[127:120] ^ rkByte(ws, 0, i);
      tmp  = tmp << 8;
    end
    for (int r = 1; r < steps && r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sboxT[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
          s[4*c+3] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rkByte(ws, r, i);
    end
    tmp = '0;
    for (int i = 0; i < 16; i++) tmp = {tmp[119:0], s[i]};
    return tmp;
  endfunction

  task automatic buildSbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sboxT[x] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    end
  endtask

  task automatic expandKey(input logic [255:0] key, input int nk, output logic [31:0] ws [60]);
    logic [31:0]  tmp;
    logic [7:0]   rcon;
    logic [255:0] k;
    rcon = 8'h01;
    k    = key;
    for (int i = 0; i < 60; i++) ws[i] = '0;
    for (int i = 0; i < nk; i++) begin
      ws[i] = k[255:224];
      k     = k << 32;
    end
    for (int i = nk; i < 4*(nk+7); i++) begin
      tmp = ws[i-1];
      if (i % nk == 0) begin
        tmp  = subWord({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'd2);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subWord(tmp);
      end
      ws[i] = ws[i-nk] ^ tmp;
    end
  endtask

  task automatic setKeys(input logic [255:0] k128, input logic [255:0] k192, input logic [255:0] k256);
    logic [1919:0] acc;
    expandKey(k128, 4, ws128);
    expandKey(k192, 6, ws192);
    expandKey(k256, 8, ws256);
    acc = '0;
    for (int i = 0; i < 44; i++) acc = {acc[1887:0], ws128[i]};
    w128 = acc[1407:0];
    acc = '0;
    for (int i = 0; i < 52; i++) acc = {acc[1887:0], ws192[i]};
    w192 = acc[1663:0];
    acc = '0;
    for (int i = 0; i < 60; i++) acc = {acc[1887:0], ws256[i]};
    w256 = acc;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "/128"}, out128, refState(ptLatched, ws128, 10, advCnt));
    checkOutput({tag, "/192"}, out192, refState(ptLatched, ws192, 12, advCnt));
    checkOutput({tag, "/256"}, out256, refState(ptLatched, ws256, 14, advCnt));
  endtask

  // Drives one clock's worth of inputs and tracks how many advancing edges the
  // cores have seen since the last restart; the plaintext is captured on the first.
  task automatic applyStimulus(input logic [127:0] pt, input logic enV, input logic s1, input logic s2);
    ptIn = pt; en = enV; set1 = s1; set2 = s2;
    @(posedge clk);
    if (s1 && s2) advCnt = 0;
    else if (!enV) begin
      if (advCnt == 0) ptLatched = pt;
      if (advCnt < 15) advCnt++;
    end
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b0; set1 = 1'b0; set2 = 1'b0; ptIn = '0;
    buildSbox();
    setKeys(K128, K192, K256);
    #12;
    checkAll("reset");
    rst_n = 1'b1;

    // Standard vectors; set1/set2 alone must not disturb the run.
    for (int e = 1; e <= 16; e++) begin
      applyStimulus((e > 11) ? rand128() : PT, 1'b0, (e % 3 == 1), (e % 3 == 2));
      checkAll("vec");
      if (e == 1)  checkOutput("vec128_e1", out128, E1);
      if (e == 2)  checkOutput("vec128_e2", out128, E2);
      if (e >= 11) checkOutput("vec128_ct", out128, C128);
      if (e >= 13) checkOutput("vec192_ct", out192, C192);
      if (e >= 15) checkOutput("vec256_ct", out256, C256);
    end

    // Three hold cycles after edge 4.
    applyStimulus(PT, 1'b0, 1'b1, 1'b1);
    checkAll("hold_restart");
    for (int e = 1; e <= 14; e++) begin
      applyStimulus((e > 1) ? rand128() : PT, (e >= 5 && e <= 7), 1'b0, 1'b0);
      checkAll("hold");
    end
    checkOutput("hold128_ct", out128, C128);

    // Restart on edge 6, then a full repeat.
    applyStimulus(PT, 1'b0, 1'b1, 1'b1);
    for (int e = 1; e <= 5; e++) begin
      applyStimulus(PT, 1'b0, 1'b0, 1'b0);
      checkAll("pre_restart");
    end
    applyStimulus(rand128(), 1'b0, 1'b1, 1'b1);
    checkOutput("restart128_zero", out128, 128'h0);
    checkAll("restart");
    for (int e = 1; e <= 11; e++) begin
      applyStimulus(PT, 1'b0, 1'b0, 1'b0);
      checkAll("rerun");
    end
    checkOutput("rerun128_ct", out128, C128);
    applyStimulus(PT, 1'b1, 1'b1, 1'b1);
    checkOutput("restart_en1_zero", out128, 128'h0);
    checkAll("restart_en1");

    // Asynchronous reset mid-round.
    for (int e = 1; e <= 3; e++) begin
      applyStimulus(PT, 1'b0, 1'b0, 1'b0);
      checkAll("pre_rst");
    end
    rst_n = 1'b0;
    #2;
    advCnt = 0;
    checkOutput("async_rst_zero", out128, 128'h0);
    checkAll("async_rst");
    #2;
    rst_n = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      applyStimulus(PT, 1'b0, 1'b0, 1'b0);
      checkAll("post_rst");
    end
    checkOutput("post_rst128_ct", out128, C128);

    // Random keys, plaintexts, holds and restarts.
    for (int t = 0; t < 6; t++) begin
      setKeys({rand128(), rand128()}, {rand128(), rand128()}, {rand128(), rand128()});
      applyStimulus(rand128(), 1'b0, 1'b1, 1'b1);
      checkAll("rand_restart");
      for (int e = 0; e < 24; e++) begin
        applyStimulus(rand128(), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 9) == 0));
        checkAll("rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
